// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle for the 4-master round-robin Wishbone arbiter: master-side request/response
// signals, the shared slave-side port, grant vector and watchdog interrupt.
interface wb_rr_arbiter_if;
    logic [127:0] m_adr_i;
    logic [127:0] m_dat_i;
    logic [15:0]  m_sel_i;
    logic [3:0]   m_we_i;
    logic [3:0]   m_cyc_i;
    logic [3:0]   m_stb_i;
    logic [31:0]  m_dat_o;
    logic [3:0]   m_ack_o;
    logic [3:0]   m_err_o;
    logic [31:0]  s_adr_o;
    logic [31:0]  s_dat_o;
    logic [3:0]   s_sel_o;
    logic         s_we_o;
    logic         s_cyc_o;
    logic         s_stb_o;
    logic [31:0]  s_dat_i;
    logic         s_ack_i;
    logic [3:0]   gnt_o;
    logic         timeout_irq_o;

    // The arbiter itself
    modport arb (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        input  s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        output gnt_o, timeout_irq_o
    );

    // Upstream masters competing for the bus
    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        input  m_dat_o, m_ack_o, m_err_o, gnt_o, timeout_irq_o
    );

    // Downstream shared slave (conbus decoder)
    modport slave (
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        output s_dat_i, s_ack_i
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: 4 masters share one slave port, ownership held for the
// whole CYC, with a watchdog that aborts unacknowledged transfers via ERR and an IRQ pulse.
module wb_rr_arbiter #(
    parameter int unsigned NUM_M   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    wb_rr_arbiter_if.arb bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    localparam bit          WDOG_EN    = (TIMEOUT != 32'd0);
    localparam logic [15:0] WDOG_LIMIT = WDOG_EN ? 16'(TIMEOUT - 32'd1) : 16'd0;

    state_e      state_r, state_nx_s;
    logic [1:0]  own_r, own_nx_s;
    logic [1:0]  last_r, last_nx_s;
    logic [3:0]  gnt_r, gnt_nx_s;
    logic [15:0] wdog_r, wdog_nx_s;
    logic [3:0]  err_r, err_nx_s;
    logic        irq_r, irq_nx_s;
    logic [2:0]  pick_s;
    logic        busy_s;
    logic        own_cyc_s;
    logic        stb_s;

    // Scan farthest-first so the requester nearest after last overwrites the others.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = int'(NUM_M); i >= 1; i--) begin
            idx = last + i[1:0];
            res = req[idx] ? {1'b1, idx} : res;
        end
        return res;
    endfunction

    assign busy_s    = (state_r == ST_BUSY);
    assign own_cyc_s = bus.m_cyc_i[own_r];
    assign stb_s     = busy_s & own_cyc_s & bus.m_stb_i[own_r];
    assign pick_s    = rr_pick(bus.m_cyc_i, last_r);

    assign bus.s_adr_o       = bus.m_adr_i[{own_r, 5'd0} +: 32];
    assign bus.s_dat_o       = bus.m_dat_i[{own_r, 5'd0} +: 32];
    assign bus.s_sel_o       = bus.m_sel_i[{own_r, 2'd0} +: 4];
    assign bus.s_we_o        = busy_s & bus.m_we_i[own_r];
    assign bus.s_cyc_o       = busy_s & own_cyc_s;
    assign bus.s_stb_o       = stb_s;
    assign bus.m_dat_o       = bus.s_dat_i;
    assign bus.m_ack_o       = (bus.s_ack_i & stb_s) ? gnt_r : 4'b0000;
    assign bus.m_err_o       = err_r;
    assign bus.gnt_o         = gnt_r;
    assign bus.timeout_irq_o = irq_r;

    // Next-state, grant rotation and watchdog decisions
    always_comb begin
        state_nx_s = state_r;
        own_nx_s   = own_r;
        last_nx_s  = last_r;
        gnt_nx_s   = gnt_r;
        wdog_nx_s  = 16'd0;
        err_nx_s   = 4'b0000;
        irq_nx_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_s[2]) begin
                    state_nx_s = ST_BUSY;
                    own_nx_s   = pick_s[1:0];
                    gnt_nx_s   = 4'b0001 << pick_s[1:0];
                end else begin
                    gnt_nx_s   = 4'b0000;
                end
            end
            ST_BUSY: begin
                if (!own_cyc_s) begin
                    state_nx_s = ST_IDLE;
                    last_nx_s  = own_r;
                    gnt_nx_s   = 4'b0000;
                end else if (WDOG_EN && stb_s && !bus.s_ack_i) begin
                    // An ACK in the limit cycle takes the else-branch below and wins.
                    if (wdog_r == WDOG_LIMIT) begin
                        state_nx_s = ST_ERR;
                        err_nx_s   = gnt_r;
                        irq_nx_s   = 1'b1;
                    end else begin
                        wdog_nx_s  = wdog_r + 16'd1;
                    end
                end else begin
                    wdog_nx_s = 16'd0;
                end
            end
            ST_ERR: begin
                state_nx_s = ST_IDLE;
                last_nx_s  = own_r;
                gnt_nx_s   = 4'b0000;
            end
            default: begin
                state_nx_s = ST_IDLE;
                gnt_nx_s   = 4'b0000;
            end
        endcase
    end

    // State, ownership, watchdog and abort-flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            own_r   <= 2'd0;
            last_r  <= 2'd3;
            gnt_r   <= 4'b0000;
            wdog_r  <= 16'd0;
            err_r   <= 4'b0000;
            irq_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            own_r   <= own_nx_s;
            last_r  <= last_nx_s;
            gnt_r   <= gnt_nx_s;
            wdog_r  <= wdog_nx_s;
            err_r   <= err_nx_s;
            irq_r   <= irq_nx_s;
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: per-cycle stimulus/expectation table run through a scoreboard
// queue, plus a hand-written watchdog sequence with a bounded wait.
module tb_wb_rr_arbiter;
    typedef struct {
        logic       rst;
        logic [3:0] cyc;
        logic       ack;
        logic [3:0] gnt;
        logic [3:0] mack;
        logic [3:0] merr;
        logic       irq;
        logic       scyc;
        logic       sstb;
    } vec_t;

    typedef struct {
        vec_t        v;
        logic [31:0] sdat;
        int          idx;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    int          n_cmp = 0;
    int          n_bad = 0;
    vec_t        tbl[$];
    exp_t        sb[$];
    logic [31:0] adr_tab [4];
    logic [31:0] dat_tab [4];
    logic [3:0]  sel_tab [4];
    logic [3:0]  we_pat = 4'b0100;
    int          stb_cnt;
    logic        seen;

    wb_rr_arbiter_if bus();

    wb_rr_arbiter #(.NUM_M(4), .TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

    function automatic void add(input logic rst, input logic [3:0] cyc, input logic ack,
                                input logic [3:0] gnt, input logic [3:0] mack,
                                input logic [3:0] merr, input logic irq,
                                input logic scyc, input logic sstb);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.ack = ack; v.gnt = gnt; v.mack = mack;
        v.merr = merr; v.irq = irq; v.scyc = scyc; v.sstb = sstb;
        tbl.push_back(v);
    endfunction

    function automatic int owner_of(input logic [3:0] g);
        for (int k = 0; k < 4; k++) begin
            if (g[k]) return k;
        end
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic compare_head();
        exp_t  e;
        int    o;
        string t;
        e = sb.pop_front();
        t = $sformatf("v%0d", e.idx);
        check({t, "_gnt"},  32'(bus.gnt_o),         32'(e.v.gnt));
        check({t, "_ack"},  32'(bus.m_ack_o),       32'(e.v.mack));
        check({t, "_err"},  32'(bus.m_err_o),       32'(e.v.merr));
        check({t, "_irq"},  32'(bus.timeout_irq_o), 32'(e.v.irq));
        check({t, "_scyc"}, 32'(bus.s_cyc_o),       32'(e.v.scyc));
        check({t, "_sstb"}, 32'(bus.s_stb_o),       32'(e.v.sstb));
        check({t, "_mdat"}, bus.m_dat_o,            e.sdat);
        if (e.v.scyc) begin
            o = owner_of(e.v.gnt);
            check({t, "_sadr"}, bus.s_adr_o,       adr_tab[o]);
            check({t, "_sdat"}, bus.s_dat_o,       dat_tab[o]);
            check({t, "_ssel"}, 32'(bus.s_sel_o),  32'(sel_tab[o]));
            check({t, "_swe"},  32'(bus.s_we_o),   32'(we_pat[o]));
        end else if (e.v.rst) begin
            check({t, "_swe"},  32'(bus.s_we_o),   32'd0);
        end
    endtask

    initial begin
        adr_tab[0] = 32'h0000_0000; dat_tab[0] = 32'hA0A0_0000; sel_tab[0] = 4'h1;
        adr_tab[1] = 32'h2000_0000; dat_tab[1] = 32'hA0A0_0001; sel_tab[1] = 4'h3;
        adr_tab[2] = 32'h4000_0000; dat_tab[2] = 32'hDEAD_BEEF; sel_tab[2] = 4'hF;
        adr_tab[3] = 32'h6000_0000; dat_tab[3] = 32'hA0A0_0003; sel_tab[3] = 4'h8;
        bus.m_adr_i = {adr_tab[3], adr_tab[2], adr_tab[1], adr_tab[0]};
        bus.m_dat_i = {dat_tab[3], dat_tab[2], dat_tab[1], dat_tab[0]};
        bus.m_sel_i = {sel_tab[3], sel_tab[2], sel_tab[1], sel_tab[0]};
        bus.m_we_i  = we_pat;
        bus.m_cyc_i = 4'b0000;
        bus.m_stb_i = 4'b0000;
        bus.s_dat_i = 32'd0;
        bus.s_ack_i = 1'b0;

        // rst cyc ack | gnt mack merr irq scyc sstb
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        // single requester: master 2 writes, slave acks in the third bus cycle
        add(1'b0, 4'b0100, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'b0000, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        // fairness from reset: grants 0,1,2,3,0, each owner drops CYC for one cycle
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'b1110, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'b1101, 1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'b1011, 1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'b0111, 1'b1, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        // rotation: master 1 finishes, then 0 and 3 tie -> 3 first, then 0
        add(1'b0, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b0010, 1'b1, 4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b1001, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b1001, 1'b1, 4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'b0001, 1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        // watchdog abort: master 0 never acked, master 1 pending
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++)
            add(1'b0, 4'b0011, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'b0011, 1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0);
        add(1'b0, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b0010, 1'b1, 4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        // ACK in the eighth strobe cycle beats the watchdog
        add(1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++)
            add(1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        // reset while master 3 strobes, then a 0/3 tie goes to master 0
        add(1'b0, 4'b1000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b1000, 1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
        add(1'b1, 4'b1000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b1001, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b1001, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'b1000, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b1000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b1000, 1'b1, 4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'b0000, 1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            exp_t e;
            @(posedge clk);
            #2;
            reset       = tbl[i].rst;
            bus.m_cyc_i = tbl[i].cyc;
            bus.m_stb_i = tbl[i].cyc;
            bus.s_ack_i = tbl[i].ack;
            e.sdat      = $urandom;
            bus.s_dat_i = e.sdat;
            e.v         = tbl[i];
            e.idx       = i;
            sb.push_back(e);
            #1;
            compare_head();
        end

        // master 2 stalls with no ACK: count strobe cycles until ERR, bounded
        @(posedge clk);
        #2;
        bus.m_cyc_i = 4'b0100;
        bus.m_stb_i = 4'b0100;
        bus.s_ack_i = 1'b0;
        stb_cnt     = 0;
        seen        = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(posedge clk);
            #3;
            if (bus.m_err_o != 4'b0000) begin
                seen = 1'b1;
            end else if (bus.s_stb_o) begin
                stb_cnt++;
            end
        end
        check("wd2_err_seen", 32'(seen), 32'd1);
        check("wd2_stb_cycles", 32'(stb_cnt), 32'd8);
        check("wd2_err", 32'(bus.m_err_o), 32'(4'b0100));
        check("wd2_irq", 32'(bus.timeout_irq_o), 32'd1);
        check("wd2_scyc", 32'(bus.s_cyc_o), 32'd0);
        bus.m_cyc_i = 4'b0000;
        bus.m_stb_i = 4'b0000;
        @(posedge clk);
        #3;
        check("wd2_gnt_after", 32'(bus.gnt_o), 32'd0);
        check("wd2_err_after", 32'(bus.m_err_o), 32'd0);
        check("wd2_irq_after", 32'(bus.timeout_irq_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
